// File: rtl/spi_sram_mem_ctrl_if.sv
// Core-side memory request bus for the serial SRAM controller.
// The core acts as master and the SPI SRAM controller as slave.
interface spi_sram_mem_ctrl_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_signed;
    logic        mem_busy;

    modport master (
        output mem_addr,
        output mem_write_data,
        output mem_read,
        output mem_write,
        output mem_size,
        output mem_signed,
        input  mem_read_data,
        input  mem_busy
    );

    modport slave (
        input  mem_addr,
        input  mem_write_data,
        input  mem_read,
        input  mem_write,
        input  mem_size,
        input  mem_signed,
        output mem_read_data,
        output mem_busy
    );
endinterface

// File: rtl/spi_sram_mem_ctrl.sv
// Memory-side slave for the multicycle RV32I core: every core access is
// served from an external serial SRAM using SPI mode 0 sequential
// READ/WRITE commands. Data travels little-endian, each byte MSB first,
// and read results are sign- or zero-extended to 32 bits.
module spi_sram_mem_ctrl #(
    parameter int         SCK_DIV   = 1,
    parameter int         ADDR_BITS = 16,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic                clk,
    input  logic                reset,
    spi_sram_mem_ctrl_if.slave  mem,
    output logic                spi_cs_n,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso
);

    localparam int                TX_BITS  = 8 + ADDR_BITS + 32;
    localparam int                DIV_W    = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        CSHI
    } state_t;

    state_t              state;
    logic                prev_req;
    logic                req;
    logic                start;
    logic [DIV_W-1:0]    div_cnt;
    logic                half_end;
    logic [5:0]          bit_cnt;
    logic [5:0]          phase_last;
    logic [5:0]          data_last;
    logic [5:0]          start_last;
    logic [TX_BITS-1:0]  tx_shift;
    logic [TX_BITS-1:0]  tx_load;
    logic [7:0]          rx_byte;
    logic [7:0]          rx_next;
    logic [31:0]         rx_word;
    logic [31:0]         read_ext;
    logic                is_read;
    logic                signed_q;
    logic [1:0]          size_q;
    logic                unused_bits;

    assign req          = mem.mem_read | mem.mem_write;
    assign start        = req & ~prev_req & (state == IDLE);
    assign mem.mem_busy = start | (state != IDLE);
    assign half_end     = (div_cnt == DIV_LAST);
    assign rx_next      = {rx_byte[6:0], spi_miso};
    assign unused_bits  = ^{mem.mem_addr[31:ADDR_BITS], rx_byte[7]};

    // Whole outgoing bit stream for one access: command, address, then the
    // store bytes in ascending byte order (all zero for reads).
    assign tx_load = {
        (mem.mem_write ? CMD_WRITE : CMD_READ),
        mem.mem_addr[ADDR_BITS-1:0],
        (mem.mem_write ? {mem.mem_write_data[7:0],   mem.mem_write_data[15:8],
                          mem.mem_write_data[23:16], mem.mem_write_data[31:24]}
                       : 32'h0)
    };

    // Index of the last data bit for the requested access size.
    always_comb begin
        start_last = 6'd31;
        case (mem.mem_size)
            2'b00:   start_last = 6'd7;
            2'b01:   start_last = 6'd15;
            default: start_last = 6'd31;
        endcase
    end

    // Index of the last bit in whichever phase is currently shifting.
    always_comb begin
        phase_last = data_last;
        case (state)
            CMD:     phase_last = 6'd7;
            ADDR:    phase_last = 6'(ADDR_BITS - 1);
            default: phase_last = data_last;
        endcase
    end

    // Received bytes collect at the top of rx_word, so short reads sit in the upper bytes.
    always_comb begin
        read_ext = rx_word;
        case (size_q)
            2'b00:   read_ext = signed_q ? {{24{rx_word[31]}}, rx_word[31:24]}
                                         : {24'h0, rx_word[31:24]};
            2'b01:   read_ext = signed_q ? {{16{rx_word[31]}}, rx_word[31:16]}
                                         : {16'h0, rx_word[31:16]};
            default: read_ext = rx_word;
        endcase
    end

    // Transfer sequencer: request edge capture, SCK generation, bit shifting and result update.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state             <= IDLE;
            prev_req          <= 1'b0;
            spi_cs_n          <= 1'b1;
            spi_sck           <= 1'b0;
            spi_mosi          <= 1'b0;
            mem.mem_read_data <= 32'h0;
            div_cnt           <= '0;
            bit_cnt           <= 6'd0;
            data_last         <= 6'd0;
            tx_shift          <= '0;
            rx_byte           <= 8'h0;
            rx_word           <= 32'h0;
            is_read           <= 1'b0;
            signed_q          <= 1'b0;
            size_q            <= 2'b00;
        end else begin
            prev_req <= req;
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= CMD;
                        spi_cs_n  <= 1'b0;
                        spi_sck   <= 1'b0;
                        spi_mosi  <= tx_load[TX_BITS-1];
                        tx_shift  <= tx_load << 1;
                        div_cnt   <= '0;
                        bit_cnt   <= 6'd0;
                        data_last <= start_last;
                        is_read   <= ~mem.mem_write;
                        signed_q  <= mem.mem_signed;
                        size_q    <= mem.mem_size;
                    end
                end
                CMD, ADDR, DATA: begin
                    if (!half_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else begin
                        div_cnt <= '0;
                        if (!spi_sck) begin
                            spi_sck <= 1'b1;
                            if (state == DATA && is_read) begin
                                rx_byte <= rx_next;
                                if (bit_cnt[2:0] == 3'd7) begin
                                    rx_word <= {rx_next, rx_word[31:8]};
                                end
                            end
                        end else begin
                            spi_sck <= 1'b0;
                            if (bit_cnt == phase_last) begin
                                bit_cnt <= 6'd0;
                                case (state)
                                    CMD:     state <= ADDR;
                                    ADDR:    state <= DATA;
                                    default: begin
                                        state    <= CSHI;
                                        spi_cs_n <= 1'b1;
                                        if (is_read) begin
                                            mem.mem_read_data <= read_ext;
                                        end
                                    end
                                endcase
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                            if (state == DATA && bit_cnt == phase_last) begin
                                spi_mosi <= 1'b0;
                            end else begin
                                spi_mosi <= tx_shift[TX_BITS-1];
                                tx_shift <= tx_shift << 1;
                            end
                        end
                    end
                end
                CSHI: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_mem_ctrl.sv
// Self-checking bench for spi_sram_mem_ctrl: two controllers (SCK_DIV=1 and
// SCK_DIV=2) talk to a behavioural serial SRAM; expectations come from a
// byte-array reference memory and the access latency formula.
module tb_spi_sram_mem_ctrl;

    logic clk = 1'b0;
    logic reset;

    logic csA, sckA, mosiA;
    logic misoA = 1'b0;
    logic csB, sckB, mosiB;
    logic misoB = 1'b0;

    int total = 0;
    int bad = 0;

    spi_sram_mem_ctrl_if busA();
    spi_sram_mem_ctrl_if busB();

    spi_sram_mem_ctrl #(
        .SCK_DIV(1), .ADDR_BITS(16), .CMD_READ(8'h03), .CMD_WRITE(8'h02)
    ) dutA (
        .clk(clk), .reset(reset), .mem(busA),
        .spi_cs_n(csA), .spi_sck(sckA), .spi_mosi(mosiA), .spi_miso(misoA)
    );

    spi_sram_mem_ctrl #(
        .SCK_DIV(2), .ADDR_BITS(16), .CMD_READ(8'h03), .CMD_WRITE(8'h02)
    ) dutB (
        .clk(clk), .reset(reset), .mem(busB),
        .spi_cs_n(csB), .spi_sck(sckB), .spi_mosi(mosiB), .spi_miso(misoB)
    );

    // Free-running system clock
    always #5 clk = ~clk;

    // Serial SRAM contents shared by both SPI buses; only bus A writes it
    logic [7:0] sram [0:65535];

    logic [7:0] rxqA[$];
    logic [7:0] lastTxA[$];
    logic [7:0] curA;
    int         bitsA = 0;
    int         csFallsA = 0;
    logic [15:0] rdAddrA;
    logic [7:0]  rdByteA;

    // SRAM model A: a new command begins at each chip-select fall
    always @(negedge csA) begin
        bitsA = 0;
        curA = 8'h0;
        rxqA.delete();
        csFallsA++;
    end

    // SRAM model A: collect MOSI bytes on rising SCK
    always @(posedge sckA) begin
        if (!csA) begin
            curA = {curA[6:0], mosiA};
            bitsA++;
            if (bitsA % 8 == 0) rxqA.push_back(curA);
        end
    end

    // SRAM model A: shift read data out on falling SCK after command and address
    always @(negedge sckA) begin
        if (!csA && bitsA >= 24 && rxqA.size() >= 3 && rxqA[0] == 8'h03) begin
            rdAddrA = 16'({rxqA[1], rxqA[2]} + (bitsA - 24) / 8);
            rdByteA = sram[rdAddrA];
            misoA = rdByteA[7 - (bitsA % 8)];
        end
    end

    // SRAM model A: commit a completed write and record the whole MOSI stream
    always @(posedge csA) begin
        lastTxA = rxqA;
        if (rxqA.size() >= 4 && rxqA[0] == 8'h02) begin
            for (int k = 3; k < rxqA.size(); k++) begin
                sram[16'({rxqA[1], rxqA[2]} + k - 3)] = rxqA[k];
            end
        end
    end

    logic [7:0]  rxqB[$];
    logic [7:0]  curB;
    int          bitsB = 0;
    logic [15:0] rdAddrB;
    logic [7:0]  rdByteB;

    // SRAM model B: start of command
    always @(negedge csB) begin
        bitsB = 0;
        curB = 8'h0;
        rxqB.delete();
    end

    // SRAM model B: collect MOSI bytes
    always @(posedge sckB) begin
        if (!csB) begin
            curB = {curB[6:0], mosiB};
            bitsB++;
            if (bitsB % 8 == 0) rxqB.push_back(curB);
        end
    end

    // SRAM model B: serve read data (bus B only reads in this bench)
    always @(negedge sckB) begin
        if (!csB && bitsB >= 24 && rxqB.size() >= 3 && rxqB[0] == 8'h03) begin
            rdAddrB = 16'({rxqB[1], rxqB[2]} + (bitsB - 24) / 8);
            rdByteB = sram[rdAddrB];
            misoB = rdByteB[7 - (bitsB % 8)];
        end
    end

    // Reference memory and expected register state, owned by the stimulus process
    logic [7:0]  refMem [0:65535];
    logic [31:0] lastRead [2];
    int          lastBusy;
    int          lastCsLow;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic driveBus(input int inst, input bit rd, input bit wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [1:0] size, input bit sgn);
        if (inst == 0) begin
            busA.mem_read = rd; busA.mem_write = wr; busA.mem_addr = addr;
            busA.mem_write_data = data; busA.mem_size = size; busA.mem_signed = sgn;
        end else begin
            busB.mem_read = rd; busB.mem_write = wr; busB.mem_addr = addr;
            busB.mem_write_data = data; busB.mem_size = size; busB.mem_signed = sgn;
        end
    endtask

    function automatic logic getBusy(input int inst);
        return (inst == 0) ? busA.mem_busy : busB.mem_busy;
    endfunction

    function automatic logic getCs(input int inst);
        return (inst == 0) ? csA : csB;
    endfunction

    function automatic logic [31:0] getReadData(input int inst);
        return (inst == 0) ? busA.mem_read_data : busB.mem_read_data;
    endfunction

    function automatic int sizeBytes(input logic [1:0] size);
        return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    endfunction

    // Expected load result: little-endian bytes from the reference memory, then extension
    function automatic logic [31:0] refLoad(input logic [15:0] a, input int nb, input bit sgn);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < nb; k++) v = v | (32'(refMem[16'(a + k)]) << (8 * k));
        if (sgn && nb < 4 && v[8 * nb - 1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        return v;
    endfunction

    // One complete core access: raise the request level, hold it while busy, then check
    task automatic applyStimulus(input int inst, input bit isWrite, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [1:0] size, input bit sgn);
        int busyCnt, csLowCnt, guard, nb, div;
        logic [7:0]  expQ[$];
        logic [31:0] expRead;
        nb  = sizeBytes(size);
        div = (inst == 0) ? 1 : 2;
        @(negedge clk);
        driveBus(inst, !isWrite, isWrite, addr, data, size, sgn);
        #1;
        busyCnt = 0; csLowCnt = 0; guard = 0;
        while (getBusy(inst) && guard < 2000) begin
            busyCnt++;
            if (getCs(inst) == 1'b0) csLowCnt++;
            @(negedge clk); #1;
            guard++;
        end
        driveBus(inst, 1'b0, 1'b0, addr, data, size, sgn);
        lastBusy = busyCnt;
        lastCsLow = csLowCnt;
        checkOutput("busy_cycles", busyCnt, 2 + 2 * div * (24 + 8 * nb));
        checkOutput("cs_low_cycles", csLowCnt, 2 * div * (24 + 8 * nb));
        if (isWrite) begin
            for (int k = 0; k < nb; k++) refMem[16'(addr[15:0] + k)] = data[8 * k +: 8];
            checkOutput("write_keeps_rdata", getReadData(inst), lastRead[inst]);
        end else begin
            expRead = refLoad(addr[15:0], nb, sgn);
            lastRead[inst] = expRead;
            checkOutput("read_data", getReadData(inst), expRead);
        end
        if (inst == 0) begin
            expQ.push_back(isWrite ? 8'h02 : 8'h03);
            expQ.push_back(addr[15:8]);
            expQ.push_back(addr[7:0]);
            for (int k = 0; k < nb; k++) expQ.push_back(isWrite ? data[8 * k +: 8] : 8'h00);
            checkOutput("mosi_len", lastTxA.size(), expQ.size());
            for (int k = 0; k < expQ.size(); k++) begin
                if (k < lastTxA.size()) checkOutput("mosi_byte", lastTxA[k], expQ[k]);
            end
        end
    endtask

    // Global time limit so a stuck design still reports
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed and randomized sequence
    initial begin
        int fallsBefore;
        int guard;
        logic [31:0] wAddr [6];
        logic [1:0]  wSize [6];
        logic [31:0] a, d;
        logic [1:0]  s, rs;
        int pick;

        lastRead[0] = 32'h0;
        lastRead[1] = 32'h0;
        reset = 1'b0;
        driveBus(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        driveBus(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_cs_n", csA, 1'b1);
        checkOutput("rst_sck", sckA, 1'b0);
        checkOutput("rst_mosi", mosiA, 1'b0);
        checkOutput("rst_rdata", busA.mem_read_data, 32'h0);
        checkOutput("rst_cs_n_b", csB, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk); #1;
        checkOutput("rst_busy", busA.mem_busy, 1'b0);

        $display("[TB] SW/LW word at 0x5F84");
        applyStimulus(0, 1'b1, 32'h0000_5F84, 32'hDEAD_BEEF, 2'b10, 1'b0);
        checkOutput("sw_busy_114", lastBusy, 114);
        checkOutput("sw_cs_low_112", lastCsLow, 112);
        applyStimulus(0, 1'b0, 32'h0000_5F84, 32'h0, 2'b10, 1'b0);
        checkOutput("lw_value", busA.mem_read_data, 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("lw_value_held", busA.mem_read_data, 32'hDEAD_BEEF);

        $display("[TB] byte and half loads with extension");
        applyStimulus(0, 1'b1, 32'h0000_0010, 32'h0000_0080, 2'b00, 1'b0);
        checkOutput("sb_busy_66", lastBusy, 66);
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b1);
        checkOutput("lb_signed", busA.mem_read_data, 32'hFFFF_FF80);
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b0);
        checkOutput("lb_unsigned", busA.mem_read_data, 32'h0000_0080);
        applyStimulus(0, 1'b1, 32'h0000_0020, 32'h0000_F234, 2'b01, 1'b0);
        checkOutput("sh_busy_82", lastBusy, 82);
        applyStimulus(0, 1'b0, 32'h0000_0020, 32'h0, 2'b01, 1'b1);
        checkOutput("lh_signed", busA.mem_read_data, 32'hFFFF_F234);
        applyStimulus(0, 1'b0, 32'h0000_0020, 32'h0, 2'b01, 1'b0);
        checkOutput("lh_unsigned", busA.mem_read_data, 32'h0000_F234);

        $display("[TB] held request level starts one access");
        fallsBefore = csFallsA;
        @(negedge clk);
        driveBus(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b0);
        #1;
        guard = 0;
        while (busA.mem_busy && guard < 2000) begin
            @(negedge clk); #1;
            guard++;
        end
        checkOutput("hold_done_in_time", {31'b0, guard < 2000}, 32'h1);
        lastRead[0] = refLoad(16'h0010, 1, 1'b0);
        checkOutput("hold_rdata", busA.mem_read_data, lastRead[0]);
        for (int i = 0; i < 3; i++) begin
            checkOutput("hold_no_restart", busA.mem_busy, 1'b0);
            @(negedge clk); #1;
        end
        driveBus(0, 1'b0, 1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b0);
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 2'b00, 1'b0);
        checkOutput("hold_cs_falls", csFallsA - fallsBefore, 2);

        $display("[TB] randomized stores then loads");
        for (int i = 0; i < 6; i++) begin
            a = ($urandom() & 32'hFFFF_0000) | (32'h1000 + $urandom_range(0, 16'h0FF0));
            d = $urandom();
            s = 2'($urandom_range(0, 3));
            wAddr[i] = a;
            wSize[i] = s;
            applyStimulus(0, 1'b1, a, d, s, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 6; i++) begin
            pick = $urandom_range(0, 5);
            rs = 2'($urandom_range(0, (wSize[pick] == 2'b11) ? 2 : int'(wSize[pick])));
            a = ($urandom() & 32'hFFFF_0000) | {16'h0, wAddr[pick][15:0]};
            applyStimulus(0, 1'b0, a, 32'h0, rs, 1'($urandom_range(0, 1)));
        end

        $display("[TB] reset during the address phase");
        applyStimulus(0, 1'b1, 32'h0000_0030, 32'h0000_0000, 2'b00, 1'b0);
        applyStimulus(0, 1'b0, 32'h0000_0030, 32'h0, 2'b00, 1'b1);
        @(negedge clk);
        driveBus(0, 1'b1, 1'b0, 32'h0000_5F84, 32'h0, 2'b10, 1'b0);
        repeat (25) @(negedge clk);
        reset = 1'b0;
        driveBus(0, 1'b0, 1'b0, 32'h0000_5F84, 32'h0, 2'b10, 1'b0);
        @(negedge clk); #1;
        checkOutput("midrst_cs_n", csA, 1'b1);
        checkOutput("midrst_sck", sckA, 1'b0);
        checkOutput("midrst_mosi", mosiA, 1'b0);
        checkOutput("midrst_busy", busA.mem_busy, 1'b0);
        checkOutput("midrst_rdata", busA.mem_read_data, lastRead[0]);
        reset = 1'b1;
        lastRead[1] = 32'h0;

        $display("[TB] word load with SCK_DIV=2");
        applyStimulus(1, 1'b0, 32'h0000_5F84, 32'h0, 2'b10, 1'b0);
        checkOutput("div2_lw_226", lastBusy, 226);
        checkOutput("div2_lw_value", busB.mem_read_data, 32'hDEAD_BEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
